mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- Arbitrates one single-port synchronous RAM port between two requesters: instruction fetch (IF) and the back-end load/store path (LS).
- Lets the core run from a single-ported memory macro instead of a dual-port RAM.
- Grants at most one access per cycle and tracks in-flight reads with an owner-tag pipeline, so each response returns to the requester that issued it.
- Fixed LS-over-IF priority, with a starvation counter that guarantees fetch progress; a branch flush discards in-flight fetch responses.

Parameters:
- ADDR_WIDTH, QU_PC_WIDTH, word address width.
- DATA_WIDTH, 32, data word width.
- RD_LATENCY, 1, RAM read latency in cycles (1..4).
- STARVE_LIMIT, 4, consecutive denied IF cycles before IF is forced priority (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- if_req  in  1  fetch read request
- if_addr  in  ADDR_WIDTH  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_WIDTH  fetch read data
- ls_req  in  1  load/store request
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_WIDTH  load/store word address
- ls_wdata  in  DATA_WIDTH  store data
- ls_gnt  out  1  load/store accepted this cycle
- ls_rvalid  out  1  load data valid
- ls_rdata  out  DATA_WIDTH  load data
- flush  in  1  mispredict flush; kills in-flight and same-cycle IF
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_din  out  DATA_WIDTH  RAM write data
- mem_dout  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after a read enable

Behaviour:
- Reset (rst=0, async): all outputs 0, starve_cnt=0, force_if=0, tag pipeline cleared. In-flight reads at reset are dropped and never produce rvalid.
- Grant is combinational from the current-cycle request.
  - force_if=0: ls_gnt=ls_req; if_gnt=if_req & !ls_req & !flush.
  - force_if=1: if_gnt=if_req & !flush; ls_gnt=ls_req & !if_gnt.
  - if_gnt and ls_gnt are never both 1.
- Memory drive:
  - mem_en = if_gnt | ls_gnt.
  - mem_we = ls_gnt & ls_we.
  - mem_addr and mem_din come from the granted requester.
  - When idle, mem_addr and mem_din hold 0.
- Starvation counter:
  - If if_req & !if_gnt & !flush, starve_cnt increments, saturating at STARVE_LIMIT.
  - If if_gnt or !if_req, starve_cnt clears to 0.
  - force_if is a register set to (starve_cnt_next == STARVE_LIMIT) and cleared on any if_gnt.
- Tag pipeline:
  - RD_LATENCY stages, each holding {valid, owner}. owner 0 = IF, 1 = LS.
  - Stage 0 is loaded with valid = mem_en & !mem_we and owner = ls_gnt.
  - Stores enter the pipeline with valid=0; stores produce no response.
- Response at the last stage:
  - if_rvalid = valid & owner==IF.
  - ls_rvalid = valid & owner==LS.
  - The owner's rdata = mem_dout; the other rdata holds 0.
- Flush:
  - Clears valid in every IF-owned stage in the same cycle, so if_rvalid is suppressed at the next edge and onward.
  - LS-owned stages are unaffected.
  - A simultaneous if_req is not granted.
- Throughput: one access per cycle, back-to-back, with no bubbles. Latency from grant to rvalid is exactly RD_LATENCY cycles.
- Requesters hold req, addr and data until they see gnt. The arbiter keeps no request queue.

Decomposition:
- Package qu_common gains:
  - typedef mem_owner_t (enum IF/LS).
  - typedef mem_tag_t (struct {valid, owner}).
  - localparam QU_MEM_STARVE_LIMIT.
- One sub-module, mem_tag_pipe: a parameterised RD_LATENCY-deep shift register of mem_tag_t with a per-owner kill input, used for the flush.

Test Plan:
- Reset: hold rst=0 with if_req=ls_req=1 → all outputs 0. Release rst → cycle 1 ls_gnt=1, if_gnt=0.
- IF alone: IF read at addr 0x10 (RAM[0x10]=0xDEADBEEF), RD_LATENCY=1 → if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, ls_rvalid=0.
- Load/store: ls store 0x55 to addr 0x20, then ls load from 0x20 → load returns ls_rdata=0x55 one cycle after its grant. No rvalid for the store.
- Starvation: ls_req=1 and if_req=1 held continuously, STARVE_LIMIT=4 → IF denied 4 cycles, granted on the 5th; LS is then granted the next cycle again.
- Flush: RD_LATENCY=2, IF read granted at cycle t, flush=1 at t+1 → no if_rvalid at t+2. An LS load granted at t+1 still returns at t+3.
- Mid-operation reset: assert rst=0 while an LS load is in flight → ls_rvalid never asserts. After release, starve_cnt restarts from 0.

Source files
------------

// File: rtl/qu_common.sv
// Shared types and constants for the core's memory-port arbitration.
package qu_common;

  localparam int QU_PC_WIDTH         = 16;
  localparam int QU_MEM_STARVE_LIMIT = 4;

  // Which requester issued an in-flight RAM read.
  typedef enum logic {
    MEM_OWNER_IF = 1'b0,
    MEM_OWNER_LS = 1'b1
  } mem_owner_t;

  // One in-flight read slot: whether it will return data and to whom.
  typedef struct packed {
    logic       valid;
    mem_owner_t owner;
  } mem_tag_t;

endpackage

// File: rtl/mem_port_arb_if.sv
// Bundle of the fetch, load/store and RAM-side signals of the memory port arbiter.
//
// Handshake: a requester raises req with addr (and ls_we/ls_wdata) stable and
// holds all of them until it sees gnt high in the same cycle; gnt is a
// combinational, single-cycle acceptance with no queueing behind it. Each
// accepted read returns exactly one rvalid pulse RD_LATENCY cycles later, in
// issue order, with no backpressure. Stores return nothing. flush cancels
// fetch reads still in flight and blocks a fetch grant in the same cycle.
interface mem_port_arb_if #(
  parameter int ADDR_WIDTH = qu_common::QU_PC_WIDTH,
  parameter int DATA_WIDTH = 32
);

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  ls_req;
  logic                  ls_we;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [DATA_WIDTH-1:0] ls_wdata;
  logic                  ls_gnt;
  logic                  ls_rvalid;
  logic [DATA_WIDTH-1:0] ls_rdata;

  logic                  flush;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, flush, mem_dout,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_din
  );

  // Core / RAM side.
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, flush, mem_dout,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/mem_tag_pipe.sv
// Owner-tag delay line that follows each RAM read through the read latency,
// with per-owner kill so a fetch flush can cancel fetch reads in flight.
module mem_tag_pipe
  import qu_common::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  mem_tag_t tag_in,
  input  logic     kill_if,
  input  logic     kill_ls,
  output mem_tag_t tag_out
);

  mem_tag_t stage_q [DEPTH];

  // A killed tag keeps its owner but no longer produces a response.
  function automatic mem_tag_t apply_kill(mem_tag_t t, logic k_if, logic k_ls);
    mem_tag_t r;
    r = t;
    if ((t.owner == MEM_OWNER_IF && k_if) || (t.owner == MEM_OWNER_LS && k_ls)) begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

  // Shift tags one stage per cycle; killed stages lose valid as they advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= apply_kill(stage_q[i-1], kill_if, kill_ls);
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arb.sv
// Single-port RAM arbiter between instruction fetch and load/store.
// Load/store normally wins; a starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive denied fetch cycles. Read responses are routed
// back to their issuer by an owner-tag pipeline matching the RAM latency.
module mem_port_arb
  import qu_common::*;
#(
  parameter int ADDR_WIDTH   = QU_PC_WIDTH,
  parameter int DATA_WIDTH   = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = QU_MEM_STARVE_LIMIT
) (
  input logic           clk,
  input logic           rst,
  mem_port_arb_if.slave bus
);

  localparam int              CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic                  if_gnt;
  logic                  ls_gnt;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [CNT_W-1:0]      starve_cnt_q;
  logic [CNT_W-1:0]      starve_cnt_d;
  logic                  force_if_q;
  logic                  force_if_d;
  mem_tag_t              tag_in;
  mem_tag_t              tag_out;
  logic                  if_rvalid;
  logic                  ls_rvalid;

  // Pick at most one requester this cycle; nothing is granted while in reset.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (rst) begin
      if (force_if_q) begin
        if_gnt = bus.if_req & ~bus.flush;
        ls_gnt = bus.ls_req & ~if_gnt;
      end else begin
        ls_gnt = bus.ls_req;
        if_gnt = bus.if_req & ~bus.ls_req & ~bus.flush;
      end
    end
  end

  // Steer the granted requester onto the RAM port; idle port drives zeros.
  always_comb begin
    mem_en   = if_gnt | ls_gnt;
    mem_we   = ls_gnt & bus.ls_we;
    mem_addr = '0;
    mem_din  = '0;
    if (ls_gnt) begin
      mem_addr = bus.ls_addr;
      mem_din  = bus.ls_wdata;
    end else if (if_gnt) begin
      mem_addr = bus.if_addr;
    end
  end

  // Count consecutive denied fetch cycles; a flush cycle neither counts nor clears.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (bus.if_req && !if_gnt && !bus.flush) begin
      starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 1'b1;
    end else if (if_gnt || !bus.if_req) begin
      starve_cnt_d = '0;
    end
    force_if_d = (starve_cnt_d == LIMIT) && !if_gnt;
  end

  // Starvation state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
      force_if_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      force_if_q   <= force_if_d;
    end
  end

  // Only reads enter the tag pipe as valid; stores ride along as bubbles.
  always_comb begin
    tag_in.valid = mem_en & ~mem_we;
    tag_in.owner = ls_gnt ? MEM_OWNER_LS : MEM_OWNER_IF;
  end

  mem_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .kill_if (bus.flush),
    .kill_ls (1'b0),
    .tag_out (tag_out)
  );

  // Route RAM read data to the owner of the oldest in-flight read.
  always_comb begin
    if_rvalid = tag_out.valid && (tag_out.owner == MEM_OWNER_IF);
    ls_rvalid = tag_out.valid && (tag_out.owner == MEM_OWNER_LS);
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_din   = mem_din;
  assign bus.if_rvalid = if_rvalid;
  assign bus.ls_rvalid = ls_rvalid;
  assign bus.if_rdata  = if_rvalid ? bus.mem_dout : '0;
  assign bus.ls_rdata  = ls_rvalid ? bus.mem_dout : '0;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: behavioural RAM, reference model with expected
// response queues, and an independent response monitor.
module tb_mem_port_arb;
  import qu_common::*;

  localparam int AW     = 8;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;
  localparam int LIMIT  = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arb #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .RD_LATENCY   (RD_LAT),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  // ---------------- behavioural RAM ----------------
  logic [DW-1:0] ram [256];
  logic [DW-1:0] rd_pipe [RD_LAT];
  bit            ram_ready = 1'b0;

  function automatic logic [DW-1:0] init_word(int a);
    return DW'(32'h9E3779B9 * (a + 1));
  endfunction

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_din;
    end
    rd_pipe[0] <= (ram_ready && bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr] : DW'($urandom);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.mem_dout = rd_pipe[RD_LAT-1];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Entries are {due_cycle[63:32], data[31:0]}.
  logic [63:0] exp_if_q [$];
  logic [63:0] exp_ls_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: arbitration rule, starvation count, shadow memory and
  // expected response times, evaluated once per cycle mid-period.
  initial begin : model
    logic [DW-1:0] shadow [256];
    int            starve_m;
    bit            force_m;
    bit            e_if, e_ls;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic [63:0]   keep [$];
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    starve_m = 0;
    force_m  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_ctl", 64'({bus.if_gnt, bus.ls_gnt, bus.mem_en, bus.mem_we}), 64'd0);
        check("rst_bus", 64'({bus.mem_addr, bus.mem_din}), 64'd0);
        starve_m = 0;
        force_m  = 1'b0;
        exp_if_q.delete();
        exp_ls_q.delete();
      end else begin
        if (force_m) begin
          e_if = bus.if_req && !bus.flush;
          e_ls = bus.ls_req && !e_if;
        end else begin
          e_ls = bus.ls_req;
          e_if = bus.if_req && !bus.ls_req && !bus.flush;
        end
        e_addr = e_ls ? bus.ls_addr : (e_if ? bus.if_addr : '0);
        e_din  = e_ls ? bus.ls_wdata : '0;
        check("gnt", 64'({bus.if_gnt, bus.ls_gnt}), 64'({e_if, e_ls}));
        check("mem_ctl", 64'({bus.mem_en, bus.mem_we}), 64'({e_if | e_ls, e_ls & bus.ls_we}));
        check("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
        check("mem_din", 64'(bus.mem_din), 64'(e_din));
        if (bus.flush) begin
          keep = {};
          foreach (exp_if_q[i]) if (int'(exp_if_q[i][63:32]) <= cyc) keep.push_back(exp_if_q[i]);
          exp_if_q = keep;
        end
        if (e_if) exp_if_q.push_back({32'(cyc + RD_LAT), shadow[bus.if_addr]});
        if (e_ls && !bus.ls_we) exp_ls_q.push_back({32'(cyc + RD_LAT), shadow[bus.ls_addr]});
        if (e_ls && bus.ls_we) shadow[bus.ls_addr] = bus.ls_wdata;
        if (bus.if_req && !e_if && !bus.flush) starve_m = (starve_m < LIMIT) ? starve_m + 1 : LIMIT;
        else if (e_if || !bus.if_req) starve_m = 0;
        force_m = (starve_m == LIMIT) && !e_if;
      end
    end
  end

  // Response monitor: pops the expected entry due this cycle and compares.
  initial begin : monitor
    bit          due_if, due_ls;
    logic [63:0] ent;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_rvalid", 64'({bus.if_rvalid, bus.ls_rvalid}), 64'd0);
        check("rst_rdata", 64'({bus.if_rdata, bus.ls_rdata}), 64'd0);
      end else begin
        due_if = (exp_if_q.size() > 0) && (int'(exp_if_q[0][63:32]) == cyc);
        due_ls = (exp_ls_q.size() > 0) && (int'(exp_ls_q[0][63:32]) == cyc);
        check("if_rvalid", 64'(bus.if_rvalid), 64'(due_if));
        check("ls_rvalid", 64'(bus.ls_rvalid), 64'(due_ls));
        if (due_if) begin
          ent = exp_if_q.pop_front();
          if (bus.if_rvalid) check("if_rdata", 64'(bus.if_rdata), 64'(ent[31:0]));
        end else if (!bus.if_rvalid) begin
          check("if_rdata_idle", 64'(bus.if_rdata), 64'd0);
        end
        if (due_ls) begin
          ent = exp_ls_q.pop_front();
          if (bus.ls_rvalid) check("ls_rdata", 64'(bus.ls_rdata), 64'(ent[31:0]));
        end else if (!bus.ls_rvalid) begin
          check("ls_rdata_idle", 64'(bus.ls_rdata), 64'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the request to be granted, then move past the granting edge.
  task automatic wait_gnt(input bit is_ls);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = is_ls ? bus.ls_gnt : bus.if_gnt;
      if (!got) step();
    end
    check(is_ls ? "ls_gnt_timeout" : "if_gnt_timeout", 64'(got), 64'd1);
    step();
  endtask

  task automatic ls_access(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.ls_req   = 1'b1;
    bus.ls_we    = we;
    bus.ls_addr  = addr;
    bus.ls_wdata = data;
    wait_gnt(1'b1);
    bus.ls_req = 1'b0;
  endtask

  task automatic if_read(input logic [AW-1:0] addr);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    wait_gnt(1'b0);
    bus.if_req = 1'b0;
  endtask

  // Both requesters held; count fetch denials before the forced grant.
  task automatic starve_run();
    int denied;
    bit got;
    denied = 0;
    got    = 1'b0;
    bus.if_req = 1'b1;
    bus.ls_req = 1'b1;
    bus.ls_we  = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.if_gnt) got = 1'b1;
      else begin
        denied++;
        step();
      end
    end
    check("starve_denied", 64'(denied), 64'(LIMIT));
    step();
    bus.if_req = 1'b0;
    @(negedge clk);
    check("ls_after_forced_if", 64'(bus.ls_gnt), 64'd1);
    step();
    bus.ls_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    bit if_took, ls_took;
    bus.if_req   = 1'b1;
    bus.if_addr  = '0;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b0;
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;
    bus.flush    = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    step();
    rst_n = 1'b1;

    // Out of reset with both requesting: LS first, fetch forced after LIMIT denials.
    starve_run();
    repeat (3) step();

    // Fetch alone.
    ls_access(1'b1, 8'h10, 32'hDEADBEEF);
    if_read(8'h10);
    repeat (3) step();

    // Store then load back.
    ls_access(1'b1, 8'h20, 32'h0000_0055);
    ls_access(1'b0, 8'h20, '0);
    repeat (3) step();

    // Flush one cycle after a fetch grant; a load granted alongside still returns.
    bus.if_req  = 1'b1;
    bus.if_addr = 8'h10;
    wait_gnt(1'b0);
    bus.if_req   = 1'b0;
    bus.flush    = 1'b1;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b0;
    bus.ls_addr  = 8'h20;
    wait_gnt(1'b1);
    bus.flush  = 1'b0;
    bus.ls_req = 1'b0;
    repeat (4) step();

    // Reset while a load is in flight; counter restarts afterwards.
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 8'h20;
    wait_gnt(1'b1);
    bus.ls_req = 1'b0;
    rst_n      = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    starve_run();
    repeat (3) step();

    // Random traffic with request holding and occasional flushes.
    if_took = 1'b0;
    ls_took = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!bus.if_req || if_took) begin
        bus.if_req  = ($urandom_range(0, 3) != 0);
        bus.if_addr = AW'($urandom_range(0, 63));
      end
      if (!bus.ls_req || ls_took) begin
        bus.ls_req   = ($urandom_range(0, 2) != 0);
        bus.ls_we    = ($urandom_range(0, 2) == 0);
        bus.ls_addr  = AW'($urandom_range(0, 63));
        bus.ls_wdata = DW'($urandom);
      end
      bus.flush = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      if_took = bus.if_gnt;
      ls_took = bus.ls_gnt;
      step();
    end

    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    bus.flush  = 1'b0;
    repeat (RD_LAT + 3) step();
    check("drain", 64'(exp_if_q.size() + exp_ls_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
